// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm codeword transmitter: state encoding,
// codeword table and the detector's membership check.
package minterm_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 4;

    // State encoding kept as plain constants so legacy code can compare raw values.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t DATA  = 2'd2;
    localparam state_t STOP  = 2'd3;

    localparam logic [2:0] CW0 = 3'b001;
    localparam logic [2:0] CW1 = 3'b010;
    localparam logic [2:0] CW2 = 3'b110;

    localparam logic [1:0] SYM_INVALID = 2'd3;

    function automatic logic [2:0] sym_to_cw(input logic [1:0] sym);
        case (sym)
            2'd0:    return CW0;
            2'd1:    return CW1;
            2'd2:    return CW2;
            default: return CW0;
        endcase
    endfunction

    // Detector: z=1 exactly for the x2,x1,x0 patterns in the codeword table.
    function automatic logic is_minterm(input logic [2:0] x);
        return (x == CW0) || (x == CW1) || (x == CW2);
    endfunction

endpackage

// File: rtl/minterm_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses tc on
// the last count and wraps; held at zero while disabled.
module minterm_baud_cnt
    import minterm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] cnt;

    assign tc = en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/minterm_tx.sv
// Serial transmitter that emits only detector minterm codewords as
// start / x2 x1 x0 / stop frames, with a valid/ready symbol handshake.
module minterm_tx
    import minterm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic [1:0] sym,
    output logic       sym_ready,
    output logic       tx,
    output logic       busy,
    output logic       err
);

    state_t     state;
    logic [2:0] data_q;
    logic [1:0] bit_idx;
    logic       tc;
    logic       accept;
    logic       sym_ok;

    assign busy      = (state != IDLE);
    // Ready in the last STOP cycle lets the next start bit follow with no gap.
    assign sym_ready = (state == IDLE) || ((state == STOP) && tc);
    assign accept    = sym_valid && sym_ready;
    assign sym_ok    = (sym != SYM_INVALID);

    minterm_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            err     <= 1'b0;
            data_q  <= '0;
            bit_idx <= '0;
        end else begin
            err <= accept && !sym_ok;
            if (accept) begin
                // An invalid symbol is consumed without a frame; the line goes idle.
                state <= sym_ok ? START : IDLE;
                if (sym_ok) begin
                    tx     <= 1'b0;
                    data_q <= sym_to_cw(sym);
                end
            end else begin
                case (state)
                    START: if (tc) begin
                        state   <= DATA;
                        tx      <= data_q[2];
                        bit_idx <= 2'd2;
                    end
                    DATA: if (tc) begin
                        if (bit_idx == 2'd0) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx - 2'd1;
                            tx      <= data_q[bit_idx - 2'd1];
                        end
                    end
                    STOP: if (tc) begin
                        state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
